// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction store: assembles big-endian words from a
// valid/ready byte stream, writes them sequentially, and serves the registered fetch port.
module instr_mem_loader #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  input  logic [31:0]       PC,
  output logic [31:0]       Inst
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [31:0]         asm_q, asm_d;
  logic [31:0]         word_next;
  logic                accept;
  logic                word_wr;
  logic                restart;
  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         inst_q;
  logic                unused_pc;

  assign unused_pc = ^{PC[31:ADDR_W+2], PC[1:0]};

  always_comb begin
    byte_ready = (state_q == LOAD);
    load_busy  = (state_q == LOAD);
    load_done  = (state_q == DONE);
    accept     = byte_valid & byte_ready;
    restart    = load_start & (state_q != LOAD);

    // Current byte merged into the partial word; low bytes stay zero on an early end.
    word_next = asm_q;
    case (byte_idx_q)
      2'd0:    word_next[31:24] = byte_data;
      2'd1:    word_next[23:16] = byte_data;
      2'd2:    word_next[15:8]  = byte_data;
      default: word_next[7:0]   = byte_data;
    endcase
    word_wr = accept & ((byte_idx_q == 2'd3) | byte_last);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load_start) state_d = LOAD;
      LOAD: if (word_wr && (byte_last || count_q == LAST_CNT)) state_d = DONE;
      DONE: if (load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_idx_d = byte_idx_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    asm_d      = asm_q;
    if (restart) begin
      byte_idx_d = '0;
      wptr_d     = '0;
      count_d    = '0;
      asm_d      = '0;
    end else if (word_wr) begin
      byte_idx_d = '0;
      wptr_d     = wptr_q + ADDR_W'(1);
      count_d    = count_q + (ADDR_W+1)'(1);
      asm_d      = '0;
    end else if (accept) begin
      byte_idx_d = byte_idx_q + 2'd1;
      asm_d      = word_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      asm_q      <= asm_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (word_wr) begin
      mem_q[wptr_q] <= word_next;
    end
  end

  // Fetch returns NOP while a load is in flight so a half-written program is never seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_q <= '0;
    end else if (state_q == LOAD) begin
      inst_q <= '0;
    end else begin
      inst_q <= mem_q[PC[ADDR_W+1:2]];
    end
  end

  assign word_count = count_q;
  assign Inst       = inst_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a byte-level model predicts memory words,
// which are checked back through the fetch port once each load completes.
module tb_instr_mem_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_last;
  logic          byte_ready;
  logic          load_busy;
  logic          load_done;
  logic [AW:0]   word_count;
  logic [31:0]   PC;
  logic [31:0]   Inst;

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .word_count (word_count),
    .PC         (PC),
    .Inst       (Inst)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_mem [DEPTH];
  int          m_idx, m_ptr, m_cnt;
  logic [31:0] m_asm;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;
  wr_t sbq[$];

  task automatic model_clear_mem();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    sbq.delete();
    m_idx = 0; m_ptr = 0; m_cnt = 0; m_asm = '0;
  endtask

  task automatic model_start();
    m_idx = 0; m_ptr = 0; m_cnt = 0; m_asm = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit last);
    m_asm[31-8*m_idx -: 8] = b;
    if (m_idx == 3 || last) begin
      exp_mem[m_ptr % DEPTH] = m_asm;
      sbq.push_back('{m_ptr % DEPTH, m_asm});
      m_ptr++; m_cnt++; m_idx = 0; m_asm = '0;
    end else begin
      m_idx++;
    end
  endtask

  // Entered and left at a negedge; byte_ready is sampled before the edge it qualifies.
  task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps, input string tag);
    bit rdy;
    bit done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0; byte_last = 1'b0;
        @(posedge clk); @(negedge clk);
      end else begin
        byte_valid = 1'b1; byte_data = b; byte_last = last;
        rdy = byte_ready;
        @(posedge clk); @(negedge clk);
        if (rdy) begin
          model_byte(b, last);
          done = 1'b1;
        end
      end
    end
    byte_valid = 1'b0; byte_last = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_handshake: byte %h accepted=0 required=1 within 40 cycles", tag, b);
    end
  endtask

  task automatic pulse_start();
    byte_valid = 1'b0; byte_last = 1'b0;
    load_start = 1'b1;
    @(posedge clk); @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 300 && !load_done; c++) @(negedge clk);
    n_checks++;
    if (load_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_timeout: load_done=%b required=1", tag, load_done);
    end
  endtask

  task automatic drain_sb(input string tag);
    wr_t w;
    while (sbq.size() > 0) begin
      w = sbq.pop_front();
      PC = 32'(w.addr) << 2;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (Inst !== w.data) begin
        n_fail++;
        $display("FAIL %s_word[%0d]: Inst=%h required=%h", tag, w.addr, Inst, w.data);
      end
    end
  endtask

  // Random upper/low PC bits exercise truncation and byte-offset ignoring.
  task automatic check_all_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      PC = ($urandom() & ~32'h0000_007C) | (32'(i) << 2);
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (Inst !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL %s_mem[%0d]: Inst=%h required=%h (PC=%h)", tag, i, Inst, exp_mem[i], PC);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; load_start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
    byte_data = '0; PC = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({byte_ready, load_busy, load_done, word_count, Inst} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b busy=%b done=%b cnt=%0d Inst=%h required all 0",
               byte_ready, load_busy, load_done, word_count, Inst);
    end
    reset = 1'b1;
    model_clear_mem();
    check_all_mem("reset");
  endtask

  task automatic test_two_words();
    logic [7:0] bytes [8] = '{8'h8C, 8'h11, 8'h00, 8'h08, 8'h8C, 8'h12, 8'h00, 8'h04};
    pulse_start(); model_start();
    n_checks++;
    if ({load_busy, byte_ready, load_done, word_count} !== {1'b1, 1'b1, 1'b0, 6'd0}) begin
      n_fail++;
      $display("FAIL two_words_enter_load: busy=%b rdy=%b done=%b cnt=%0d required 1 1 0 0",
               load_busy, byte_ready, load_done, word_count);
    end
    for (int i = 0; i < 8; i++) send_byte(bytes[i], i == 7, 1'b0, "two_words");
    wait_done("two_words");
    n_checks++;
    if (word_count !== 6'(m_cnt) || m_cnt != 2) begin
      n_fail++;
      $display("FAIL two_words_count: word_count=%0d required=2", word_count);
    end
    drain_sb("two_words");
    PC = 32'h0; @(posedge clk); @(negedge clk);
    PC = 32'h4;
    n_checks++;
    if (Inst !== 32'h8C110008) begin
      n_fail++;
      $display("FAIL fetch_latency_hold: Inst=%h required=8c110008", Inst);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (Inst !== 32'h8C120004) begin
      n_fail++;
      $display("FAIL fetch_pc4: Inst=%h required=8c120004", Inst);
    end
  endtask

  task automatic test_partial();
    logic [7:0] bytes [6] = '{8'h02, 8'h32, 8'h40, 8'h20, 8'hAA, 8'hBB};
    pulse_start(); model_start();
    for (int i = 0; i < 6; i++) send_byte(bytes[i], i == 5, 1'b0, "partial");
    wait_done("partial");
    n_checks++;
    if (word_count !== 6'd2) begin
      n_fail++;
      $display("FAIL partial_count: word_count=%0d required=2", word_count);
    end
    drain_sb("partial");
    check_all_mem("partial");
  endtask

  task automatic test_full_random();
    pulse_start(); model_start();
    for (int i = 0; i < 128; i++) send_byte(8'(i), 1'b0, 1'b1, "full");
    wait_done("full");
    n_checks++;
    if ({word_count, byte_ready} !== {6'd32, 1'b0}) begin
      n_fail++;
      $display("FAIL full_end: word_count=%0d rdy=%b required 32 0", word_count, byte_ready);
    end
    byte_valid = 1'b1; byte_data = 8'hFF; byte_last = 1'b1;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0; byte_last = 1'b0;
    n_checks++;
    if ({word_count, byte_ready, load_done} !== {6'd32, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL full_extra_byte: word_count=%0d rdy=%b done=%b required 32 0 1",
               word_count, byte_ready, load_done);
    end
    drain_sb("full");
    PC = 32'h7C; @(posedge clk); @(negedge clk);
    n_checks++;
    if (Inst !== 32'h7C7D7E7F) begin
      n_fail++;
      $display("FAIL full_mem31: Inst=%h required=7c7d7e7f", Inst);
    end
    check_all_mem("full");
  endtask

  task automatic test_full_and_last();
    pulse_start(); model_start();
    for (int i = 0; i < 128; i++) send_byte(8'(8'hFF - i), i == 127, 1'b0, "full_last");
    wait_done("full_last");
    repeat (3) @(negedge clk);
    n_checks++;
    if ({word_count, load_done, load_busy} !== {6'd32, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL full_last_count: word_count=%0d done=%b busy=%b required 32 1 0",
               word_count, load_done, load_busy);
    end
    drain_sb("full_last");
  endtask

  task automatic test_restart_and_fetch();
    logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    pulse_start(); model_start();
    n_checks++;
    if ({word_count, load_busy} !== {6'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL done_restart: word_count=%0d busy=%b required 0 1", word_count, load_busy);
    end
    PC = 32'h0; @(posedge clk); @(negedge clk);
    n_checks++;
    if (Inst !== 32'h0) begin
      n_fail++;
      $display("FAIL fetch_nop_in_load: Inst=%h required=00000000", Inst);
    end
    send_byte(bytes[0], 1'b0, 1'b0, "restart");
    send_byte(bytes[1], 1'b0, 1'b0, "restart");
    pulse_start();
    n_checks++;
    if ({load_busy, word_count} !== {1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL start_in_load: busy=%b cnt=%0d required 1 0", load_busy, word_count);
    end
    for (int i = 2; i < 6; i++) send_byte(bytes[i], i == 5, 1'b0, "restart");
    wait_done("restart");
    n_checks++;
    if (word_count !== 6'd2) begin
      n_fail++;
      $display("FAIL restart_count: word_count=%0d required=2", word_count);
    end
    drain_sb("restart");
    PC = 32'h0; @(posedge clk); @(negedge clk);
    n_checks++;
    if (Inst !== 32'h11223344) begin
      n_fail++;
      $display("FAIL fetch_after_done: Inst=%h required=11223344", Inst);
    end
    PC = 32'h84; @(posedge clk); @(negedge clk);
    n_checks++;
    if (Inst !== 32'h55660000) begin
      n_fail++;
      $display("FAIL fetch_wrap_84: Inst=%h required=55660000", Inst);
    end
    check_all_mem("restart");
  endtask

  task automatic test_mid_reset();
    pulse_start(); model_start();
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0, 1'b0, "mid_reset");
    reset = 1'b0;
    #1;
    n_checks++;
    if ({byte_ready, load_busy, load_done, word_count, Inst} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: rdy=%b busy=%b done=%b cnt=%0d Inst=%h required all 0",
               byte_ready, load_busy, load_done, word_count, Inst);
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear_mem();
    PC = 32'h0; @(posedge clk); @(negedge clk);
    n_checks++;
    if ({load_busy, load_done, byte_ready, Inst} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: busy=%b done=%b rdy=%b Inst=%h required all 0",
               load_busy, load_done, byte_ready, Inst);
    end
    check_all_mem("mid_reset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_words();
    test_partial();
    test_full_random();
    test_full_and_last();
    test_restart_and_fetch();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the CPU instruction store: accepts a byte stream over a valid/ready handshake, assembles 32-bit big-endian words, and writes them sequentially into a DEPTH-word instruction memory.
- Provides the word-addressed fetch read port the single-cycle datapath uses: `Inst` is registered on posedge from byte address `PC`.
- Replaces the hard-coded initial program with a loadable one.
- Sits between the board/test host byte source and the datapath fetch stage.

Parameters:
- DEPTH, 32, number of 32-bit instruction words (power of two).
- ADDR_W, 5, log2(DEPTH); word-pointer width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a program load.
- byte_valid  in  1  source has a byte on `byte_data`.
- byte_data  in  8  program byte, most-significant byte of each word first.
- byte_last  in  1  qualifies `byte_data` as the final byte of the program.
- byte_ready  out  1  loader can accept a byte this cycle.
- load_busy  out  1  high while in LOAD.
- load_done  out  1  high in DONE (level).
- word_count  out  ADDR_W+1  words written by the current/last load.
- PC  in  32  fetch byte address.
- Inst  out  32  registered fetched instruction.

Behaviour:
- Reset, asserted asynchronously while reset=0, forces:
  - state IDLE;
  - byte_ready=0, load_busy=0, load_done=0;
  - word_count=0, byte index=0, word pointer=0, assembly register=0;
  - Inst=0;
  - all DEPTH memory words=0.
- Reset asserted mid-load aborts the load with the same result; nothing partially loaded survives.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: byte_ready=0. load_start=1 moves to LOAD next cycle and clears word_count, byte index and word pointer.
  - LOAD: byte_ready=1, load_busy=1. load_start is ignored (no restart).
  - DONE: load_done=1, byte_ready=0. load_start=1 moves to LOAD with the same clearing as from IDLE.
- Byte handshake: a byte is accepted on a posedge where byte_valid & byte_ready; no acceptance otherwise. The source must hold the byte while byte_valid=1 and byte_ready=0.
- Word assembly: byte index 0..3.
  - Accepted byte k is placed at bits [31-8k : 24-8k].
  - On acceptance of byte index 3, the completed word is written to mem[word pointer] on the same edge, the word pointer increments, word_count increments and the byte index returns to 0.
- Early end (byte_last=1 on an accepted byte):
  - Any partial word is written with the unreceived low bytes set to 0.
  - word_count increments by 1.
  - The FSM goes to DONE next cycle.
- Full end: when word_count reaches DEPTH, the FSM goes to DONE. byte_ready deasserts the cycle after the final write; no further bytes are accepted.
- Full and last together: if byte_last coincides with the DEPTH-th word completing, a single DONE transition occurs and word_count=DEPTH (no overflow, no wrap).
- Memory locations not written by a load keep their previous contents.
- Fetch:
  - Every posedge, Inst <= mem[PC[ADDR_W+1:2]].
  - PC[1:0] is ignored. PC above 4*DEPTH-1 wraps by truncation.
  - Latency is 1 cycle.
  - While in LOAD, Inst <= 0 (NOP), so the core never fetches a half-written program.
  - In IDLE/DONE, reads are unconditional.

Test Plan:
- Reset then load_start. Stream 8 bytes 8C,11,00,08,8C,12,00,04 with byte_last on the 8th byte → mem[0]=8C110008, mem[1]=8C120004, word_count=2, load_done=1. Then PC=4 → Inst=8C120004 one cycle later.
- Stream 6 bytes 02,32,40,20,AA,BB with byte_last on BB → mem[1]=AABB0000, word_count=2, remaining words keep their values.
- Toggle byte_valid randomly on a 128-byte stream of incrementing values 00..7F without byte_last:
  - mem[31]=7C7D7E7F, word_count=32;
  - byte_ready=0 afterwards, and a 129th valid byte is not accepted.
- Assert reset=0 after 5 accepted bytes, then release → state IDLE, word_count=0, Inst=0, mem[0]=0.
- During LOAD, drive PC=0 with mem[0] nonzero from a prior load → Inst=0. After DONE → Inst=mem[0]. PC=32'h84 → reads mem[1] (wrap).
- In DONE, pulse load_start → new load begins with word_count=0; load_start pulsed during LOAD has no effect.
